cart_header_parser: RTL and testbench



---
 rtl/cart_header_parser.sv | 150 +++++++++++++++
 tb/tb_cart_header_parser.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_header_parser.sv
// Snoops the ROM download stream, captures the cartridge header,
// verifies its checksum and detects MBC1 multicarts for the bank controller.
module cart_header_parser #(
  parameter int          LOGO_BYTES    = 16,
  parameter logic [22:0] MIRROR_OFFSET = 23'h040000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [22:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic [7:0]  cart_mbc_type,
  output logic [7:0]  cart_rom_size,
  output logic [7:0]  cart_ram_size,
  output logic [7:0]  cart_cgb_flag,
  output logic [7:0]  cart_sgb_flag,
  output logic        mbc1m,
  output logic        hdr_chk_ok,
  output logic        rom_oversize,
  output logic        hdr_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

  localparam int          HDR_BYTES = 26;
  localparam logic [22:0] LOGO_BASE = 23'h000104;
  localparam logic [22:0] HDR_BASE  = 23'h000134;
  localparam logic [22:0] MIR_BASE  = MIRROR_OFFSET + LOGO_BASE;
  localparam logic [22:0] MIR_LAST  = MIR_BASE + 23'(LOGO_BYTES) - 23'd1;

  state_t          state;
  logic            old_active;
  logic [7:0]      hdr  [HDR_BYTES];
  logic [7:0]      logo [LOGO_BYTES];
  logic [LOGO_BYTES-1:0] match;
  logic [22:0]     max_addr;
  logic [4:0]      idx;
  logic [7:0]      acc;

  logic rise;
  logic fall;
  logic capture;
  logic type_mbc1;
  logic rom_big;

  assign rise    = dl_active & ~old_active;
  assign fall    = ~dl_active & old_active;
  assign capture = dl_active & dl_wr & (rise | (state == LOAD));

  assign type_mbc1 = (hdr[19] == 8'h01) | (hdr[19] == 8'h02) |
                     (hdr[19] == 8'h03);
  assign rom_big   = (hdr[20] <= 8'd8) &
                     ({1'b0, max_addr} >= (24'h008000 << hdr[20]));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      // track the live level so a download already under way
      // does not look like a fresh rising edge once reset drops
      old_active    <= dl_active;
      max_addr      <= '0;
      match         <= '0;
      idx           <= '0;
      acc           <= '0;
      cart_mbc_type <= '0;
      cart_rom_size <= '0;
      cart_ram_size <= '0;
      cart_cgb_flag <= '0;
      cart_sgb_flag <= '0;
      mbc1m         <= 1'b0;
      hdr_chk_ok    <= 1'b0;
      rom_oversize  <= 1'b0;
      hdr_valid     <= 1'b0;
      for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= '0;
      for (int i = 0; i < LOGO_BYTES; i++) logo[i] <= '0;
    end else begin
      old_active <= dl_active;

      if (rise) begin
        state         <= LOAD;
        max_addr      <= '0;
        match         <= '0;
        idx           <= '0;
        acc           <= '0;
        cart_mbc_type <= '0;
        cart_rom_size <= '0;
        cart_ram_size <= '0;
        cart_cgb_flag <= '0;
        cart_sgb_flag <= '0;
        mbc1m         <= 1'b0;
        hdr_chk_ok    <= 1'b0;
        rom_oversize  <= 1'b0;
        hdr_valid     <= 1'b0;
        for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= '0;
        for (int i = 0; i < LOGO_BYTES; i++) logo[i] <= '0;
      end else begin
        unique case (state)
          LOAD: begin
            if (fall) begin
              state <= CHECK;
              idx   <= '0;
              acc   <= '0;
            end
          end
          CHECK: begin
            if (idx == 5'(HDR_BYTES - 1)) begin
              state         <= DONE;
              hdr_chk_ok    <= (acc == hdr[25]);
              cart_cgb_flag <= hdr[15];
              cart_sgb_flag <= hdr[18];
              cart_mbc_type <= hdr[19];
              cart_rom_size <= hdr[20];
              cart_ram_size <= hdr[21];
              mbc1m         <= (&match) & type_mbc1 &
                               (max_addr >= MIR_LAST);
              rom_oversize  <= rom_big;
              hdr_valid     <= 1'b1;
            end else begin
              acc <= acc - hdr[idx] - 8'd1;
              idx <= idx + 5'd1;
            end
          end
          IDLE: ;
          DONE: ;
          default: ;
        endcase
      end

      // a write in the rising-edge cycle lands on top of the clear
      if (capture) begin
        for (int i = 0; i < LOGO_BYTES; i++) begin
          if (dl_addr == LOGO_BASE + 23'(i)) logo[i] <= dl_data;
          if (dl_addr == MIR_BASE + 23'(i))
            match[i] <= (dl_data == (rise ? 8'h00 : logo[i]));
        end
        for (int i = 0; i < HDR_BYTES; i++) begin
          if (dl_addr == HDR_BASE + 23'(i)) hdr[i] <= dl_data;
        end
        if (rise || (dl_addr > max_addr)) max_addr <= dl_addr;
      end
    end
  end

endmodule

// File: tb/tb_cart_header_parser.sv
// Randomized bench for cart_header_parser against an image-level
// reference model, plus directed header/multicart/oversize cases.
module tb_cart_header_parser;

  localparam logic [22:0] MIR = 23'h040000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [22:0] dl_addr;
  logic [7:0]  dl_data;
  logic [7:0]  cart_mbc_type;
  logic [7:0]  cart_rom_size;
  logic [7:0]  cart_ram_size;
  logic [7:0]  cart_cgb_flag;
  logic [7:0]  cart_sgb_flag;
  logic        mbc1m;
  logic        hdr_chk_ok;
  logic        rom_oversize;
  logic        hdr_valid;

  cart_header_parser dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .dl_active     (dl_active),
    .dl_wr         (dl_wr),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .cart_mbc_type (cart_mbc_type),
    .cart_rom_size (cart_rom_size),
    .cart_ram_size (cart_ram_size),
    .cart_cgb_flag (cart_cgb_flag),
    .cart_sgb_flag (cart_sgb_flag),
    .mbc1m         (mbc1m),
    .hdr_chk_ok    (hdr_chk_ok),
    .rom_oversize  (rom_oversize),
    .hdr_valid     (hdr_valid)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                 $time);
    end
  endtask

  // image-level reference model
  logic [7:0]  m_hdr  [26];
  logic [7:0]  m_logo [16];
  bit          m_match[16];
  logic [22:0] m_max;
  bit          m_old, m_load;
  int          m_cnt;
  logic [7:0]  e_type, e_rom, e_ram, e_cgb, e_sgb;
  bit          e_mbc1m, e_chk, e_over, e_valid;

  task automatic m_clear();
    foreach (m_hdr[i]) m_hdr[i] = 8'h00;
    foreach (m_logo[i]) begin
      m_logo[i]  = 8'h00;
      m_match[i] = 1'b0;
    end
    m_max = '0;
    {e_type, e_rom, e_ram, e_cgb, e_sgb} = '0;
    {e_mbc1m, e_chk, e_over, e_valid} = '0;
  endtask

  task automatic m_finalize();
    logic [7:0] a;
    bit all_m;
    a = 8'h00;
    for (int i = 0; i < 25; i++) a = a - m_hdr[i] - 8'd1;
    e_chk  = (a == m_hdr[25]);
    e_cgb  = m_hdr[8'h0F];
    e_sgb  = m_hdr[8'h12];
    e_type = m_hdr[8'h13];
    e_rom  = m_hdr[8'h14];
    e_ram  = m_hdr[8'h15];
    all_m  = 1'b1;
    foreach (m_match[i]) all_m &= m_match[i];
    e_mbc1m = all_m && (e_type inside {8'h01, 8'h02, 8'h03}) &&
              (int'(m_max) >= int'(MIR) + 'h104 + 15);
    e_over  = (e_rom <= 8) &&
              (longint'(m_max) >= (longint'(32768) << e_rom));
    e_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        m_clear();
        m_old  = dl_active;
        m_load = 1'b0;
        m_cnt  = -1;
      end else begin
        if (dl_active && !m_old) begin
          m_clear();
          m_load = 1'b1;
          m_cnt  = -1;
        end
        if (m_load && dl_active && dl_wr) begin
          int a;
          a = int'(dl_addr);
          if (a >= 'h104 && a < 'h114) m_logo[a - 'h104] = dl_data;
          if (a >= 'h134 && a <= 'h14D) m_hdr[a - 'h134] = dl_data;
          if (a >= int'(MIR) + 'h104 && a < int'(MIR) + 'h114)
            m_match[a - int'(MIR) - 'h104] =
              (dl_data == m_logo[a - int'(MIR) - 'h104]);
          if (dl_addr > m_max) m_max = dl_addr;
        end
        if (m_load && !dl_active && m_old) begin
          m_load = 1'b0;
          m_cnt  = 26;
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) m_finalize();
        end
        m_old = dl_active;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    @(posedge clk_sys);
    forever begin
      @(negedge clk_sys);
      chk("valid", hdr_valid, e_valid);
      chk("type", cart_mbc_type, e_type);
      chk("rom", cart_rom_size, e_rom);
      chk("ram", cart_ram_size, e_ram);
      chk("cgb", cart_cgb_flag, e_cgb);
      chk("sgb", cart_sgb_flag, e_sgb);
      chk("mbc1m", mbc1m, e_mbc1m);
      chk("chk_ok", hdr_chk_ok, e_chk);
      chk("oversize", rom_oversize, e_over);
    end
  end

  // stimulus image
  logic [7:0] h   [26];
  logic [7:0] lg  [16];
  logic [7:0] mir [16];
  bit         gaps;

  function automatic logic [7:0] hsum();
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < 25; i++) a = a - h[i] - 8'd1;
    return a;
  endfunction

  task automatic wr(input logic [22:0] a, input logic [7:0] d);
    if (gaps && $urandom_range(3) == 0) @(negedge clk_sys);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    @(negedge clk_sys);
    dl_wr = 1'b0;
  endtask

  task automatic send(input logic [22:0] top, input bit mirror);
    dl_active = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 16; i++) wr(23'h104 + 23'(i), lg[i]);
    for (int i = 0; i < 26; i++) wr(23'h134 + 23'(i), h[i]);
    if (mirror)
      for (int i = 0; i < 16; i++) wr(MIR + 23'h104 + 23'(i), mir[i]);
    wr(top, 8'($urandom));
    dl_active = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (hdr_valid !== 1'b1 && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    chk("done_timeout", hdr_valid, 1);
    @(negedge clk_sys);
  endtask

  task automatic clr_img();
    foreach (h[i]) h[i] = 8'h00;
    lg = '{8'hCE, 8'hED, 8'h66, 8'h66, 8'hCC, 8'h0D, 8'h00, 8'h0B,
           8'h03, 8'h73, 8'h00, 8'h83, 8'h00, 8'h0C, 8'h00, 8'h0D};
    mir = lg;
  endtask

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; gaps = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_valid", hdr_valid, 0);
    chk("rst_type", cart_mbc_type, 0);
    chk("rst_chk", hdr_chk_ok, 0);

    // plain 32 KB image with exact latency check
    clr_img();
    h[25] = 8'hE7;
    send(23'h7FFF, 1'b0);
    @(posedge clk_sys);
    repeat (25) @(posedge clk_sys);
    #1 chk("lat25", hdr_valid, 0);
    @(posedge clk_sys);
    #1 chk("lat26", hdr_valid, 1);
    @(negedge clk_sys);
    chk("plain_chk", hdr_chk_ok, 1);
    chk("plain_type", cart_mbc_type, 0);
    chk("plain_mbc1m", mbc1m, 0);
    chk("plain_over", rom_oversize, 0);

    // checksum failure
    h[25] = 8'hE6;
    send(23'h7FFF, 1'b0);
    wait_done();
    chk("bad_chk", hdr_chk_ok, 0);

    // MBC1 multicart and its negatives
    clr_img();
    h[8'h13] = 8'h01;
    h[8'h14] = 8'h05;
    h[25] = hsum();
    send(23'hFFFFF, 1'b1);
    wait_done();
    chk("m1m_yes", mbc1m, 1);
    chk("m1m_chk", hdr_chk_ok, 1);
    chk("m1m_over", rom_oversize, 0);
    mir[11] = 8'hFF;
    send(23'hFFFFF, 1'b1);
    wait_done();
    chk("m1m_corrupt", mbc1m, 0);
    mir = lg;
    h[8'h13] = 8'h19;
    send(23'hFFFFF, 1'b1);
    wait_done();
    chk("m1m_type19", mbc1m, 0);

    // oversize boundaries
    clr_img();
    h[8'h14] = 8'h01;
    send(23'h10000, 1'b0);
    wait_done();
    chk("over_64k", rom_oversize, 1);
    send(23'h0FFFF, 1'b0);
    wait_done();
    chk("fit_64k", rom_oversize, 0);
    h[8'h14] = 8'h52;
    send(23'h1FFFFF, 1'b0);
    wait_done();
    chk("over_52", rom_oversize, 0);

    // restart during CHECK
    clr_img();
    h[8'h13] = 8'h05;
    send(23'h7FFF, 1'b0);
    repeat (10) @(negedge clk_sys);
    chk("rs_mid", hdr_valid, 0);
    h[8'h13] = 8'h03;
    h[25] = hsum();
    send(23'h7FFF, 1'b0);
    wait_done();
    chk("rs_type", cart_mbc_type, 8'h03);
    chk("rs_chk", hdr_chk_ok, 1);

    // reset mid-load; the stream continuing afterwards is ignored
    clr_img();
    h[8'h13] = 8'h05;
    dl_active = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 20; i++) wr(23'h134 + 23'(i), h[i]);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    chk("rl_valid", hdr_valid, 0);
    chk("rl_type", cart_mbc_type, 0);
    for (int i = 0; i < 26; i++) wr(23'h134 + 23'(i), h[i]);
    dl_active = 1'b0;
    repeat (40) @(negedge clk_sys);
    chk("rl_ignored", hdr_valid, 0);
    chk("rl_type2", cart_mbc_type, 0);

    // write on the same cycle as the rising edge
    dl_active = 1'b1;
    dl_wr = 1'b1;
    dl_addr = 23'h147;
    dl_data = 8'h1B;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    dl_active = 1'b0;
    wait_done();
    chk("edge_wr", cart_mbc_type, 8'h1B);
    chk("edge_chk", hdr_chk_ok, 0);

    // randomized images
    gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int t;
      logic [22:0] top;
      foreach (h[i]) h[i] = 8'($urandom);
      foreach (lg[i]) lg[i] = 8'($urandom);
      t = $urandom_range(5);
      h[8'h13] = (t < 4) ? 8'(t) : ((t == 4) ? 8'h19 : 8'($urandom));
      t = $urandom_range(9);
      h[8'h14] = (t <= 7) ? 8'(t) : 8'(8'h52 + $urandom_range(2));
      if ($urandom_range(1) == 1) h[25] = hsum();
      mir = lg;
      if ($urandom_range(2) == 0) mir[$urandom_range(15)] ^= 8'h01;
      top = (23'h8000 << $urandom_range(7)) - 23'd1 +
            23'($urandom_range(2));
      if ($urandom_range(3) == 0) wr(23'h147, 8'($urandom));
      send(top, $urandom_range(3) != 0);
      if ($urandom_range(4) == 0) begin
        repeat ($urandom_range(1, 24)) @(negedge clk_sys);
      end else begin
        wait_done();
      end
    end
    gaps = 1'b0;
    repeat (40) @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
